// File: rtl/frame_buffer_arbiter.sv
// Frame buffer write arbiter: MCM (strict priority) and four LCBs (round-robin) share one write port into a ping-pong buffer.
// Latency: a request seen in IDLE is written/acked on the next cycle; at most one word per two clocks.
// Backpressure: requesters hold req/data until their one-cycle ack; full regions are acked but not written.
module frame_buffer_arbiter #(
  parameter int MCM_DEPTH = 256,
  parameter int LCB_DEPTH = 192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        iSwitch,
  input  logic        iMCM_req,
  input  logic [11:0] iMCM_data,
  input  logic [3:0]  iLCB_req,
  input  logic [47:0] iLCB_data,
  output logic        oMCM_ack,
  output logic [3:0]  oLCB_ack,
  output logic        oWrEn,
  output logic [10:0] oWrAddr,
  output logic [11:0] oWrData,
  output logic [4:0]  oOvf,
  output logic        oBank
);

  typedef enum logic [1:0] {IDLE, WRITE, SWAP} state_t;

  // Requester index 0 is the MCM, 1..4 are LCB1..LCB4; same order as oOvf.
  state_t      state_q, state_d;
  logic        sw_q;
  logic        pend_q, pend_d;
  logic        bank_q, bank_d;
  logic [10:0] ptr_q [5];
  logic [10:0] ptr_d [5];
  logic [4:0]  frm_ovf_q, frm_ovf_d;
  logic [4:0]  ovf_q, ovf_d;
  logic [1:0]  rr_q, rr_d;
  logic        wr_en_q, wr_en_d;
  logic [10:0] wr_addr_q, wr_addr_d;
  logic [11:0] wr_data_q, wr_data_d;
  logic [4:0]  ack_q, ack_d;

  logic        sw_edge;
  logic        win_vld;
  logic [2:0]  win;
  logic [1:0]  win_lcb;
  logic [1:0]  idx;
  logic [11:0] win_data;
  logic [10:0] win_ptr;
  logic        win_full;
  int          base;
  int          depth;

  assign sw_edge = (iSwitch != sw_q);

  // Pick the winner: MCM first, then LCBs starting from the one after the last granted.
  always_comb begin
    win_vld = 1'b0;
    win     = 3'd0;
    win_lcb = 2'd0;
    idx     = 2'd0;
    if (iMCM_req) begin
      win_vld = 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        idx = rr_q + 2'(i);
        if (!win_vld && iLCB_req[idx]) begin
          win_vld = 1'b1;
          win_lcb = idx;
          win     = {1'b0, idx} + 3'd1;
        end
      end
    end
  end

  // Region geometry, current pointer and data of the winner.
  always_comb begin
    if (win == 3'd0) begin
      base     = 0;
      depth    = MCM_DEPTH;
      win_data = iMCM_data;
    end else begin
      base     = MCM_DEPTH + int'(win_lcb) * LCB_DEPTH;
      depth    = LCB_DEPTH;
      win_data = iLCB_data[int'(win_lcb) * 12 +: 12];
    end
    win_ptr  = ptr_q[win];
    win_full = (int'(win_ptr) >= depth);
  end

  // Next-state logic; write strobe, address, data and ack are registered so they appear in the WRITE cycle.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q | sw_edge;
    bank_d    = bank_q;
    ptr_d     = ptr_q;
    frm_ovf_d = frm_ovf_q;
    ovf_d     = ovf_q;
    rr_d      = rr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;
    ack_d     = '0;
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = SWAP;
        end else if (win_vld) begin
          state_d    = WRITE;
          ack_d[win] = 1'b1;
          wr_data_d  = win_data;
          if (!win_full) begin
            wr_en_d    = 1'b1;
            wr_addr_d  = {bank_q, 10'(base + int'(win_ptr))};
            ptr_d[win] = win_ptr + 11'd1;
          end else begin
            // Region full: ack so the requester moves on, but drop the word and flag it.
            wr_addr_d      = {bank_q, 10'(base + depth - 1)};
            frm_ovf_d[win] = 1'b1;
          end
          if (win != 3'd0) rr_d = win_lcb + 2'd1;
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      SWAP: begin
        state_d   = IDLE;
        bank_d    = ~bank_q;
        for (int r = 0; r < 5; r++) ptr_d[r] = '0;
        ovf_d     = frm_ovf_q;
        frm_ovf_d = '0;
        pend_d    = sw_edge;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset; write bank starts opposite the reader.
  always_ff @(posedge clk) begin
    sw_q <= iSwitch;
    if (reset) begin
      state_q   <= IDLE;
      pend_q    <= 1'b0;
      bank_q    <= ~iSwitch;
      for (int r = 0; r < 5; r++) ptr_q[r] <= '0;
      frm_ovf_q <= '0;
      ovf_q     <= '0;
      rr_q      <= 2'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ack_q     <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      bank_q    <= bank_d;
      ptr_q     <= ptr_d;
      frm_ovf_q <= frm_ovf_d;
      ovf_q     <= ovf_d;
      rr_q      <= rr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ack_q     <= ack_d;
    end
  end

  assign oMCM_ack = ack_q[0];
  assign oLCB_ack = ack_q[4:1];
  assign oWrEn    = wr_en_q;
  assign oWrAddr  = wr_addr_q;
  assign oWrData  = wr_data_q;
  assign oOvf     = ovf_q;
  assign oBank    = bank_q;

endmodule
